// File: rtl/key_bytes_to_words.sv
// RC5 key expansion, first stage: folds key bytes K[B-1..0] into the little-endian
// word array L[], one byte per clock, and streams each updated word out.
module key_bytes_to_words #(
    parameter int W = 32,
    parameter int B = 16,
    parameter int C = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8*B-1:0] key,
    output logic [W-1:0]   L_sub_i,
    output logic [W-1:0]   L_sub_i_prima
);

    localparam int U  = W / 8;
    localparam int IW = (B > 1) ? $clog2(B) : 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    logic [8*B-1:0] key_q;
    logic [W-1:0]   l_mem [C];
    logic [IW-1:0]  i_q;
    logic           done;

    logic [CW-1:0]  idx;
    logic [7:0]     k_byte;
    logic [W-1:0]   new_word;

    // (L << 8) + K leaves the low byte of the shifted word zero, so the add is a
    // plain byte append; bits shifted past W-1 fall off the top.
    always_comb begin
        idx      = CW'(int'(i_q) / U);
        k_byte   = key_q[8*i_q +: 8];
        new_word = {l_mem[idx][W-9:0], k_byte};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q         <= key;
            // NOTE: the word array is cleared by a loop because every restart must
            // begin from an all-zero L, not because memories normally need a reset.
            for (int c = 0; c < C; c++) begin
                l_mem[c] <= '0;
            end
            i_q           <= IW'(B - 1);
            done          <= 1'b0;
            L_sub_i       <= '0;
            L_sub_i_prima <= '0;
        end else if (!done) begin
            // NOTE: non-blocking assignments let L_sub_i_prima capture the word
            // value from before this edge's update.
            L_sub_i_prima <= l_mem[idx];
            L_sub_i       <= new_word;
            l_mem[idx]    <= new_word;
            if (i_q == '0) begin
                done <= 1'b1;
            end else begin
                i_q <= i_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_bytes_to_words.sv
// Self-checking bench for key_bytes_to_words: scoreboard against a behavioural
// model, plus table checks of known RC5 byte-folding values.
module tb_key_bytes_to_words;

    localparam int W = 32;
    localparam int B = 16;
    localparam int C = 4;
    localparam int U = W / 8;

    localparam logic [8*B-1:0] KEY1 = 128'hFFFEEEE58684FFF05FFE493853000434;
    localparam logic [8*B-1:0] KEY2 = {B{8'h01}};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [8*B-1:0] key = '0;
    logic [W-1:0]   L_sub_i;
    logic [W-1:0]   L_sub_i_prima;

    always #5 clk = ~clk;

    key_bytes_to_words #(.W(W), .B(B), .C(C)) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .L_sub_i      (L_sub_i),
        .L_sub_i_prima(L_sub_i_prima)
    );

    typedef struct packed {
        logic [W-1:0] sub;
        logic [W-1:0] prima;
    } exp_t;

    typedef struct {
        int           edge_n;
        logic [W-1:0] sub;
        logic [W-1:0] prima;
    } vec_t;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];
    vec_t tbl1[$];
    vec_t tbl2[$];

    logic [W-1:0] obs_sub   [31];
    logic [W-1:0] obs_prima [31];
    logic [W-1:0] ref_sub   [31];
    logic [W-1:0] ref_prima [31];

    // Behavioural reference state
    logic [8*B-1:0] m_key;
    logic [W-1:0]   m_l [C];
    int             m_i;
    bit             m_done;
    logic [W-1:0]   m_sub;
    logic [W-1:0]   m_prima;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void model_reset(input logic [8*B-1:0] k);
        m_key = k;
        for (int c = 0; c < C; c++) m_l[c] = '0;
        m_i     = B - 1;
        m_done  = 1'b0;
        m_sub   = '0;
        m_prima = '0;
    endfunction

    function automatic void model_step();
        int           widx;
        logic [7:0]   kb;
        if (!m_done) begin
            widx       = m_i / U;
            kb         = m_key[8*m_i +: 8];
            m_prima    = m_l[widx];
            m_l[widx]  = (m_l[widx] << 8) + W'(kb);
            m_sub      = m_l[widx];
            if (m_i == 0) m_done = 1'b1;
            else          m_i    = m_i - 1;
        end
    endfunction

    task automatic reset_edge(input logic [8*B-1:0] k);
        exp_t e;
        rst = 1'b1;
        key = k;
        model_reset(k);
        sb_q.push_back('{sub: m_sub, prima: m_prima});
        @(posedge clk); #1;
        e = sb_q.pop_front();
        check("reset_sub", L_sub_i, e.sub);
        check("reset_prima", L_sub_i_prima, e.prima);
        rst = 1'b0;
    endtask

    task automatic step_edge(input int n);
        exp_t e;
        model_step();
        sb_q.push_back('{sub: m_sub, prima: m_prima});
        @(posedge clk); #1;
        e = sb_q.pop_front();
        check($sformatf("edge%0d_sub", n), L_sub_i, e.sub);
        check($sformatf("edge%0d_prima", n), L_sub_i_prima, e.prima);
        obs_sub[n]   = L_sub_i;
        obs_prima[n] = L_sub_i_prima;
    endtask

    initial begin
        tbl1.push_back('{1,  32'h000000FF, 32'h00000000});
        tbl1.push_back('{2,  32'h0000FFFE, 32'h000000FF});
        tbl1.push_back('{3,  32'h00FFFEEE, 32'h0000FFFE});
        tbl1.push_back('{4,  32'hFFFEEEE5, 32'h00FFFEEE});
        tbl1.push_back('{5,  32'h00000086, 32'h00000000});
        tbl1.push_back('{8,  32'h8684FFF0, 32'h008684FF});
        tbl1.push_back('{9,  32'h0000005F, 32'h00000000});
        tbl1.push_back('{12, 32'h5FFE4938, 32'h005FFE49});
        tbl1.push_back('{13, 32'h00000053, 32'h00000000});
        tbl1.push_back('{16, 32'h53000434, 32'h00530004});
        tbl1.push_back('{17, 32'h53000434, 32'h00530004});
        tbl1.push_back('{30, 32'h53000434, 32'h00530004});

        tbl2.push_back('{1,  32'h00000001, 32'h00000000});
        tbl2.push_back('{2,  32'h00000101, 32'h00000001});
        tbl2.push_back('{4,  32'h01010101, 32'h00010101});
        tbl2.push_back('{5,  32'h00000001, 32'h00000000});
        tbl2.push_back('{16, 32'h01010101, 32'h00010101});
        tbl2.push_back('{20, 32'h01010101, 32'h00010101});

        // Reset values, byte order, word boundaries, completion and hold
        reset_edge(KEY1);
        for (int n = 1; n <= 30; n++) step_edge(n);
        for (int v = 0; v < tbl1.size(); v++) begin
            check($sformatf("tbl1_e%0d_sub", tbl1[v].edge_n), obs_sub[tbl1[v].edge_n], tbl1[v].sub);
            check($sformatf("tbl1_e%0d_prima", tbl1[v].edge_n), obs_prima[tbl1[v].edge_n], tbl1[v].prima);
        end
        for (int n = 1; n <= 30; n++) begin
            ref_sub[n]   = obs_sub[n];
            ref_prima[n] = obs_prima[n];
        end

        // Mid-run reset with a new key
        reset_edge(KEY1);
        for (int n = 1; n <= 6; n++) step_edge(n);
        reset_edge(KEY2);
        for (int n = 1; n <= 20; n++) step_edge(n);
        for (int v = 0; v < tbl2.size(); v++) begin
            check($sformatf("tbl2_e%0d_sub", tbl2[v].edge_n), obs_sub[tbl2[v].edge_n], tbl2[v].sub);
            check($sformatf("tbl2_e%0d_prima", tbl2[v].edge_n), obs_prima[tbl2[v].edge_n], tbl2[v].prima);
        end

        // Key changes while running must not disturb the sequence
        reset_edge(KEY1);
        for (int n = 1; n <= 30; n++) begin
            if (n == 3)  key = KEY2;
            if (n == 10) key = {$urandom, $urandom, $urandom, $urandom};
            step_edge(n);
        end
        for (int n = 1; n <= 30; n += 1) begin
            if (n % 4 == 1 || n >= 16) begin
                check($sformatf("keychg_e%0d_sub", n), obs_sub[n], ref_sub[n]);
                check($sformatf("keychg_e%0d_prima", n), obs_prima[n], ref_prima[n]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
